// File: rtl/prog_counter_bank_if.sv
// Host register bus for prog_counter_bank: active-low strobes, address, split data.
// Read data returns registered one cycle after the sampled read strobe.
interface prog_counter_bank_if #(
  parameter int AW    = 4,
  parameter int CNT_W = 16
);
  logic             csq;
  logic             wrq;
  logic             rdq;
  logic [AW-1:0]    abus;
  logic [CNT_W-1:0] dbus_i;
  logic [CNT_W-1:0] dbus_o;
  logic             rd_vld;

  modport master (
    output csq, wrq, rdq, abus, dbus_i,
    input  dbus_o, rd_vld
  );

  modport slave (
    input  csq, wrq, rdq, abus, dbus_i,
    output dbus_o, rd_vld
  );
endinterface

// File: rtl/prog_counter_bank.sv
// Bank of NUM_CH programmable down-counters (periodic / one-shot / square) with a register bus.
// Writes land on the sampled edge; reads return one cycle later; no backpressure.
module prog_counter_bank #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  localparam int AW     = (($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1) + 2
) (
  input  logic                sclk,
  input  logic                rstq,
  prog_counter_bank_if.slave  bus,
  input  logic [NUM_CH-1:0]   gate,
  input  logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   cout,
  output logic                irq
);

  localparam int CHW = AW - 2;

  localparam logic [1:0] REG_RELOAD = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_PERIODIC = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_SQUARE   = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;

  logic [CNT_W-1:0]  reload_q [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [1:0]        mode_q   [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] ie_q;
  logic [NUM_CH-1:0] flag_q;
  logic [NUM_CH-1:0] cout_q;

  logic [CHW-1:0]    sel_ch;
  logic [1:0]        reg_sel;
  logic              wr_req;
  logic              rd_req;

  logic [NUM_CH-1:0] wr_reload;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_stat;
  logic [NUM_CH-1:0] cnt_cyc;
  logic [NUM_CH-1:0] term;
  logic [CNT_W-1:0]  rd_mux;

  assign sel_ch  = bus.abus[AW-1:2];
  assign reg_sel = bus.abus[1:0];
  assign wr_req  = ~bus.csq & ~bus.wrq;
  // A simultaneous write strobe wins; the read is dropped.
  assign rd_req  = ~bus.csq & ~bus.rdq & bus.wrq;

  // Per-channel write decode and count qualification. A CTRL write cycle does
  // not count so the new configuration takes over cleanly on the next edge.
  always_comb begin
    wr_reload = '0;
    wr_ctrl   = '0;
    wr_stat   = '0;
    cnt_cyc   = '0;
    term      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_req && (sel_ch == CHW'(c))) begin
        case (reg_sel)
          REG_RELOAD: wr_reload[c] = 1'b1;
          REG_CTRL:   wr_ctrl[c]   = 1'b1;
          REG_STATUS: wr_stat[c]   = 1'b1;
          default:    ;
        endcase
      end
      cnt_cyc[c] = en_q[c] & gate[c] & tick[c] & (mode_q[c] != MODE_RSVD) & ~wr_ctrl[c];
      term[c]    = cnt_cyc[c] & (count_q[c] == '0);
    end
  end

  always_ff @(posedge sclk or negedge rstq) begin
    if (!rstq) begin
      for (int c = 0; c < NUM_CH; c++) begin
        reload_q[c] <= '0;
        count_q[c]  <= '0;
        mode_q[c]   <= MODE_PERIODIC;
      end
      en_q   <= '0;
      ie_q   <= '0;
      flag_q <= '0;
      cout_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cnt_cyc[c]) begin
          if (!term[c]) begin
            count_q[c] <= count_q[c] - CNT_W'(1);
          end else if (mode_q[c] == MODE_ONESHOT) begin
            en_q[c] <= 1'b0;
          end else begin
            count_q[c] <= reload_q[c];
          end
        end

        case (mode_q[c])
          MODE_PERIODIC: cout_q[c] <= term[c];
          MODE_ONESHOT:  if (term[c]) cout_q[c] <= 1'b1;
          MODE_SQUARE:   if (term[c]) cout_q[c] <= ~cout_q[c];
          default:       cout_q[c] <= 1'b0;
        endcase

        // A terminal event in the same cycle as a write-1-clear keeps the flag.
        flag_q[c] <= term[c] | (flag_q[c] & ~(wr_stat[c] & bus.dbus_i[0]));

        if (wr_ctrl[c]) begin
          en_q[c]   <= bus.dbus_i[0];
          mode_q[c] <= bus.dbus_i[2:1];
          ie_q[c]   <= bus.dbus_i[3];
          if (!en_q[c] && bus.dbus_i[0]) begin
            count_q[c] <= reload_q[c];
            cout_q[c]  <= 1'b0;
          end
        end

        // RELOAD write overrides whatever the count path decided this cycle.
        if (wr_reload[c]) begin
          reload_q[c] <= bus.dbus_i;
          count_q[c]  <= bus.dbus_i;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == CHW'(c)) begin
        case (reg_sel)
          REG_RELOAD: rd_mux = reload_q[c];
          REG_CTRL:   rd_mux = CNT_W'({ie_q[c], mode_q[c], en_q[c]});
          REG_COUNT:  rd_mux = count_q[c];
          default:    rd_mux = CNT_W'(flag_q[c]);
        endcase
      end
    end
  end

  always_ff @(posedge sclk or negedge rstq) begin
    if (!rstq) begin
      bus.dbus_o <= '0;
      bus.rd_vld <= 1'b0;
    end else begin
      bus.dbus_o <= rd_req ? rd_mux : '0;
      bus.rd_vld <= rd_req;
    end
  end

  always_comb begin
    cout = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cout[c] = cout_q[c] & (mode_q[c] != MODE_RSVD);
    end
  end

  assign irq = |(flag_q & ie_q);

endmodule
